// File: rtl/mem_seq_pkg.sv
// Shared types for the memory access sequencer: FSM states, grant encoding,
// strobe bundle and the state-to-strobe decode.
package mem_seq_pkg;

   localparam int DEF_ADDR_W = 16;
   localparam int DEF_DATA_W = 16;

   typedef enum logic [2:0] {
      IDLE, LD_MAR, LD_MDR, MEM_RD, MEM_WR, RD_GET, DONE
   } state_t;

   typedef enum logic {
      GNT_IF = 1'b0,
      GNT_LS = 1'b1
   } gnt_t;

   typedef struct packed {
      logic marce;
      logic mdrce;
      logic mdrput;
      logic maroe;
      logic mdroe;
      logic mdrget;
      logic mem_read;
      logic mem_write;
   } strobe_t;

   // Strobes depend on state alone, so requests never reach them combinationally.
   function automatic strobe_t decode_strobes(state_t s);
      strobe_t st;
      st = '0;
      case (s)
         LD_MAR: st.marce = 1'b1;
         LD_MDR: begin st.mdrce = 1'b1; st.mdrput = 1'b1; end
         MEM_WR: begin st.mem_write = 1'b1; st.maroe = 1'b1; st.mdroe = 1'b1; end
         MEM_RD: begin st.mem_read = 1'b1; st.maroe = 1'b1; st.mdrce = 1'b1; end
         RD_GET: begin st.mdrget = 1'b1; st.mdroe = 1'b1; end
         default: ;
      endcase
      return st;
   endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Requester handshakes, internal data bus and controller strobes of the sequencer.
interface mem_access_sequencer_if #(
   parameter int ADDR_W = mem_seq_pkg::DEF_ADDR_W,
   parameter int DATA_W = mem_seq_pkg::DEF_DATA_W
);
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              ls_req;
   logic              ls_we;
   logic [ADDR_W-1:0] ls_addr;
   logic [DATA_W-1:0] ls_wdata;
   logic              ls_ack;
   logic [DATA_W-1:0] ls_rdata;
   logic              bus_err;
   logic [DATA_W-1:0] int_bus_out;
   logic [DATA_W-1:0] int_bus_in;
   logic              marce, mdrce, mdrput, maroe, mdroe, mdrget, mem_read, mem_write;
   logic              mem_ready;
   logic              busy;

   modport slave (
      input  if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, int_bus_in, mem_ready,
      output if_ack, if_rdata, ls_ack, ls_rdata, bus_err, int_bus_out,
             marce, mdrce, mdrput, maroe, mdroe, mdrget, mem_read, mem_write, busy
   );

   modport master (
      output if_req, if_addr, ls_req, ls_we, ls_addr, ls_wdata, int_bus_in, mem_ready,
      input  if_ack, if_rdata, ls_ack, ls_rdata, bus_err, int_bus_out,
             marce, mdrce, mdrput, maroe, mdroe, mdrget, mem_read, mem_write, busy
   );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Two-way round-robin arbiter between instruction fetch and load/store.
module mem_rr_arbiter
   import mem_seq_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic if_req,
   input  logic ls_req,
   input  logic accept,
   output gnt_t grant,
   output logic any_req
);
   gnt_t last_grant;

   // On a tie the requester that did not win last time goes first.
   always_comb begin
      any_req = if_req | ls_req;
      if (if_req && ls_req) grant = (last_grant == GNT_IF) ? GNT_LS : GNT_IF;
      else if (ls_req)      grant = GNT_LS;
      else                  grant = GNT_IF;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         last_grant <= GNT_IF;
      else if (accept) last_grant <= grant;
   end
endmodule

// File: rtl/mem_access_sequencer.sv
// Turns IF / LS single-word requests into ordered MAR/MDR controller strobes,
// with wait states, a ready handshake and a per-phase timeout.
module mem_access_sequencer
   import mem_seq_pkg::*;
#(
   parameter int          ADDR_W      = DEF_ADDR_W,
   parameter int          DATA_W      = DEF_DATA_W,
   parameter int unsigned WAIT_STATES = 1,
   parameter int unsigned TIMEOUT_CYC = 15
) (
   input logic clk,
   input logic rst,
   mem_access_sequencer_if.slave bus
);
   localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

   state_t            state, nxt;
   gnt_t              grant, gnt_q;
   logic              any_req, accept;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] wdata_q;
   logic              we_q;
   logic [3:0]        wait_cnt;
   logic [TO_W-1:0]   to_cnt;
   logic              err_q;
   logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;
   logic              mem_phase, mem_done, timed_out, entering;
   strobe_t           stb;

   mem_rr_arbiter u_arb (
      .clk     (clk),
      .rst     (rst),
      .if_req  (bus.if_req),
      .ls_req  (bus.ls_req),
      .accept  (accept),
      .grant   (grant),
      .any_req (any_req)
   );

   assign accept    = (state == IDLE) && any_req;
   assign mem_phase = (state == MEM_RD) || (state == MEM_WR);
   assign mem_done  = (wait_cnt == 4'd0) && bus.mem_ready;
   // A normal exit on the last allowed cycle wins over the timeout.
   assign timed_out = mem_phase && !mem_done && (to_cnt == TO_W'(TIMEOUT_CYC - 1));
   assign entering  = !mem_phase && ((nxt == MEM_RD) || (nxt == MEM_WR));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (any_req) nxt = LD_MAR;
         LD_MAR:  nxt = we_q ? LD_MDR : MEM_RD;
         LD_MDR:  nxt = MEM_WR;
         MEM_RD:  if (mem_done) nxt = RD_GET; else if (timed_out) nxt = DONE;
         MEM_WR:  if (mem_done || timed_out) nxt = DONE;
         RD_GET:  nxt = DONE;
         DONE:    nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         gnt_q      <= GNT_IF;
         addr_q     <= '0;
         wdata_q    <= '0;
         we_q       <= 1'b0;
         wait_cnt   <= 4'd0;
         to_cnt     <= '0;
         err_q      <= 1'b0;
         if_rdata_q <= '0;
         ls_rdata_q <= '0;
      end else begin
         if (accept) begin
            gnt_q   <= grant;
            addr_q  <= (grant == GNT_LS) ? bus.ls_addr : bus.if_addr;
            wdata_q <= bus.ls_wdata;
            we_q    <= (grant == GNT_LS) && bus.ls_we;
         end
         if (entering) begin
            wait_cnt <= 4'(WAIT_STATES);
            to_cnt   <= '0;
         end else if (mem_phase) begin
            if (wait_cnt != 4'd0) wait_cnt <= wait_cnt - 4'd1;
            to_cnt <= to_cnt + TO_W'(1);
         end
         if (timed_out)          err_q <= 1'b1;
         else if (state == DONE) err_q <= 1'b0;
         // A timed-out read returns zero instead of whatever was on the bus.
         if (state == RD_GET || (state == MEM_RD && timed_out)) begin
            if (gnt_q == GNT_LS) ls_rdata_q <= (state == RD_GET) ? bus.int_bus_in : '0;
            else                 if_rdata_q <= (state == RD_GET) ? bus.int_bus_in : '0;
         end
      end
   end

   always_comb begin
      stb             = decode_strobes(state);
      bus.int_bus_out = '0;
      if (state == LD_MAR)      bus.int_bus_out = DATA_W'(addr_q);
      else if (state == LD_MDR) bus.int_bus_out = wdata_q;
   end

   assign bus.marce     = stb.marce;
   assign bus.mdrce     = stb.mdrce;
   assign bus.mdrput    = stb.mdrput;
   assign bus.maroe     = stb.maroe;
   assign bus.mdroe     = stb.mdroe;
   assign bus.mdrget    = stb.mdrget;
   assign bus.mem_read  = stb.mem_read;
   assign bus.mem_write = stb.mem_write;
   assign bus.if_ack    = (state == DONE) && (gnt_q == GNT_IF);
   assign bus.ls_ack    = (state == DONE) && (gnt_q == GNT_LS);
   assign bus.bus_err   = (state == DONE) && err_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.ls_rdata  = ls_rdata_q;
   assign bus.busy      = (state != IDLE);
endmodule

// File: doc/mem_access_sequencer.md
Name: mem_access_sequencer

Overview:
- Sequences the MAR/MDR memory bus controller and shares it between two requesters: instruction fetch (IF) and load/store (LS).
- Converts single-request read/write transactions into the ordered control strobes: marce, mdrce, mdrput, maroe, mem_read/mem_write, mdroe, mdrget.
- Sits between the core pipeline and the memory bus controller.
- Provides 2-way round-robin arbitration, programmable wait states, a ready handshake and a bus timeout.

Parameters:
- ADDR_W, 16, address width driven onto the internal bus.
- DATA_W, 16, data width.
- WAIT_STATES, 1, minimum extra cycles held in a memory phase (0..15).
- TIMEOUT_CYC, 15, maximum cycles in a memory phase before bus error (must be > WAIT_STATES).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; asynchronous, active-high.
- if_req  in  1  fetch request; held until if_ack.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle completion pulse to IF.
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1.
- ls_req  in  1  load/store request; held until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_ack  out  1  one-cycle completion pulse to LS.
- ls_rdata  out  DATA_W  load data; valid while ls_ack=1.
- bus_err  out  1  timeout flag; valid with the ack.
- int_bus_out  out  DATA_W  value driven onto the internal data bus.
- int_bus_in  in  DATA_W  internal data bus readback.
- marce, mdrce, mdrput, maroe, mdroe, mdrget, mem_read, mem_write  out  1 each  controller strobes.
- mem_ready  in  1  memory ready.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (asynchronous):
  - state=IDLE; all strobes, acks and bus_err = 0.
  - if_rdata, ls_rdata and int_bus_out = 0.
  - last_grant=IF; wait and timeout counters = 0.
- IDLE:
  - On any req, grant, latch addr/wdata/we internally, set busy next cycle, go LD_MAR.
  - Requests sampled only in IDLE; no acceptance in DONE.
- Arbitration, round-robin:
  - Both requesting: grant the one not equal to last_grant.
  - last_grant updates on accept.
  - First tie after reset goes to LS; ties then alternate LS, IF, LS.
- LD_MAR (1 cycle): marce=1, int_bus_out=latched addr. Store goes to LD_MDR; load/fetch goes to MEM_RD.
- LD_MDR (1 cycle): mdrce=1, mdrput=1, int_bus_out=wdata; go to MEM_WR.
- MEM_WR: mem_write=1, maroe=1, mdroe=1.
- MEM_RD: mem_read=1, maroe=1, mdrce=1.
- Memory phases (MEM_WR/MEM_RD):
  - On entry, wait counter loads WAIT_STATES.
  - Exit when counter==0 and mem_ready=1; counter decrements each cycle while nonzero.
  - MEM_RD exits to RD_GET; MEM_WR exits to DONE.
  - Timeout counter counts cycles in phase. Reaching TIMEOUT_CYC forces DONE with error flag set; captured read data = 0.
- RD_GET (1 cycle): mdrget=1, mdroe=1; int_bus_in captured into rdata register; go to DONE.
- DONE (1 cycle):
  - Granted requester's ack=1; its rdata holds the captured word (stores: unchanged).
  - bus_err = error flag; error flag cleared afterwards.
  - Go to IDLE.
- Latency, WAIT_STATES=0 and mem_ready=1: ack in the 4th cycle after the accepting IDLE edge, for both read and write. Each wait state or not-ready cycle adds 1.
- Invariants:
  - mem_read and mem_write never both 1.
  - marce never coincides with any other strobe.
  - Strobes are registered/decoded from state only (no req-to-strobe combinational path).
- Requester drops req mid-transaction: transaction completes, ack still pulses.
- Non-granted req is held pending; served on the next IDLE.
- int_bus_out = 0 outside LD_MAR/LD_MDR.

Decomposition:
- Package mem_seq_pkg holds:
  - state enum: IDLE, LD_MAR, LD_MDR, MEM_RD, MEM_WR, RD_GET, DONE;
  - grant encoding: GNT_IF=0, GNT_LS=1;
  - default ADDR_W/DATA_W constants.
- One sub-module, mem_rr_arbiter: 2-way round-robin with last_grant register and accept strobe.

Test Plan:
- Reset mid-MEM_RD (WAIT_STATES=3) -> next cycle all strobes 0, busy=0, no ack; then ls_req load 0x0040 completes normally.
- WAIT_STATES=0, mem_ready=1, if_req addr 0x0100, int_bus_in=0xBEEF in RD_GET -> strobe sequence marce; mem_read+maroe+mdrce; mdrget+mdroe; then if_ack=1 with if_rdata=0xBEEF, 4 cycles after accept.
- ls store addr 0x0020, data 0x1234 -> int_bus_out=0x0020 with marce, then 0x1234 with mdrput+mdrce, then mem_write+maroe+mdroe, then ls_ack=1, bus_err=0.
- if_req and ls_req held high together from reset for 4 transactions -> grants LS, IF, LS, IF; no ack ever to both in the same cycle.
- WAIT_STATES=2, mem_ready low for 3 extra cycles in MEM_RD -> phase lasts exactly 4 cycles; ack 3 cycles later than the WAIT_STATES=0 case.
- mem_ready stuck 0, TIMEOUT_CYC=15 -> after 15 MEM_RD cycles: DONE, ack=1, bus_err=1, rdata=0x0000; next transaction has bus_err=0.
